// File: rtl/bp_update_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// bp_update_scheduler_pkg
//   Shared definitions for the branch-predictor update scheduler.
//   - Default PC / depth / counter widths.
//   - Update entry layout: {pc, taken}. The taken flag sits in the LSB and the PC
//     occupies the bits above it. The predictor uses the same layout.
//   - FIFO operation encoding used by bp_update_fifo.
// -----------------------------------------------------------------------------
package bp_update_scheduler_pkg;

    localparam int PC_WIDTH_DEFAULT  = 32;
    localparam int DEPTH_DEFAULT     = 4;
    localparam int CNT_WIDTH_DEFAULT = 32;

    // Position of the taken flag inside an entry; the PC sits directly above it.
    localparam int ENTRY_TAKEN_LSB = 0;

    // Width of one {pc, taken} entry.
    function automatic int entry_width(input int pc_width);
        return pc_width + 1;
    endfunction

    // Combined push/pop request seen by the FIFO in a cycle, encoded as {pop, push}.
    typedef enum logic [1:0] {
        FIFO_IDLE = 2'b00,
        FIFO_PUSH = 2'b01,
        FIFO_POP  = 2'b10,
        FIFO_BOTH = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/bp_update_fifo.sv
// -----------------------------------------------------------------------------
// bp_update_fifo
//   Synchronous DEPTH x (PC_WIDTH+1) FIFO holding {pc, taken} update entries.
//   Full and empty are decided from the occupancy counter, not from pointer
//   equality. The pointers wrap modulo DEPTH, so DEPTH must be a power of 2.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   i_push, i_pc, i_taken write request and data; ignored while full
//   i_pop                 read request; ignored while empty
//   o_head_pc/o_head_taken entry at the head of the FIFO
//   o_occupancy           number of entries held (0..DEPTH)
//   o_valid, o_pc_vec     per-slot valid flag and PC, used for the stale-guess compare
// -----------------------------------------------------------------------------
module bp_update_fifo
    import bp_update_scheduler_pkg::*;
#(
    parameter  int PC_WIDTH = PC_WIDTH_DEFAULT,
    parameter  int DEPTH    = DEPTH_DEFAULT,
    localparam int EW       = entry_width(PC_WIDTH),
    localparam int PTR_W    = $clog2(DEPTH),
    localparam int OCC_W    = PTR_W + 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_push,
    input  logic [PC_WIDTH-1:0]            i_pc,
    input  logic                           i_taken,
    input  logic                           i_pop,
    output logic [PC_WIDTH-1:0]            o_head_pc,
    output logic                           o_head_taken,
    output logic [OCC_W-1:0]               o_occupancy,
    output logic [DEPTH-1:0]               o_valid,
    output logic [DEPTH-1:0][PC_WIDTH-1:0] o_pc_vec
);

    logic [EW-1:0]    r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_occ;

    logic             w_push;
    logic             w_pop;
    fifo_op_e         w_op;
    logic [EW-1:0]    w_head;

    assign w_push = i_push && (r_occ != OCC_W'(DEPTH));
    assign w_pop  = i_pop  && (r_occ != {OCC_W{1'b0}});
    assign w_op   = fifo_op_e'({w_pop, w_push});

    assign w_head       = r_mem[r_rd_ptr];
    assign o_head_pc    = w_head[EW-1:ENTRY_TAKEN_LSB+1];
    assign o_head_taken = w_head[ENTRY_TAKEN_LSB];
    assign o_occupancy  = r_occ;

    // A slot is live when its distance from the read pointer is below the occupancy.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        logic [PTR_W-1:0] w_off;
        assign w_off          = PTR_W'(gi) - r_rd_ptr;
        assign o_valid[gi]    = ({1'b0, w_off} < r_occ);
        assign o_pc_vec[gi]   = r_mem[gi][EW-1:ENTRY_TAKEN_LSB+1];
    end

    // Storage, pointers and occupancy; a simultaneous push and pop leaves occupancy unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {EW{1'b0}};
            end
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_occ    <= {OCC_W{1'b0}};
        end else begin
            case (w_op)
                FIFO_PUSH: begin
                    r_mem[r_wr_ptr] <= {i_pc, i_taken};
                    r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
                    r_occ           <= r_occ + OCC_W'(1);
                end
                FIFO_POP: begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                    r_occ    <= r_occ - OCC_W'(1);
                end
                FIFO_BOTH: begin
                    r_mem[r_wr_ptr] <= {i_pc, i_taken};
                    r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
                    r_rd_ptr        <= r_rd_ptr + PTR_W'(1);
                end
                default: begin
                    r_occ <= r_occ;
                end
            endcase
        end
    end

endmodule

// File: rtl/bp_update_scheduler.sv
// -----------------------------------------------------------------------------
// bp_update_scheduler
//   Buffers resolved branches from execute and issues at most one update per
//   cycle to the branch predictor's check/update port. Non-branch records are
//   accepted and dropped. Issue pauses while hold is high. pending_hit flags a
//   fetch guess whose PC is still queued or is being issued, so fetch knows that
//   prediction may be stale.
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   in_valid/in_ready                 execute handshake
//   in_pc/in_is_br/in_taken           resolved record
//   hold                              pipeline stall, blocks issue
//   pc_guess/pending_hit              stale-prediction compare (combinational)
//   pc_check/is_br_check/br_taken_check registered predictor update port
//   occupancy                         FIFO fill level
//   issued_count                      updates issued since reset (wraps)
// -----------------------------------------------------------------------------
module bp_update_scheduler
    import bp_update_scheduler_pkg::*;
#(
    parameter  int PC_WIDTH  = PC_WIDTH_DEFAULT,
    parameter  int DEPTH     = DEPTH_DEFAULT,
    parameter  int CNT_WIDTH = CNT_WIDTH_DEFAULT,
    localparam int OCC_W     = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PC_WIDTH-1:0]  in_pc,
    input  logic                 in_is_br,
    input  logic                 in_taken,
    input  logic                 hold,
    input  logic [PC_WIDTH-1:0]  pc_guess,
    output logic                 pending_hit,
    output logic [PC_WIDTH-1:0]  pc_check,
    output logic                 is_br_check,
    output logic                 br_taken_check,
    output logic [OCC_W-1:0]     occupancy,
    output logic [CNT_WIDTH-1:0] issued_count
);

    logic [OCC_W-1:0]               w_occ;
    logic [PC_WIDTH-1:0]            w_head_pc;
    logic                           w_head_taken;
    logic [DEPTH-1:0]               w_valid;
    logic [DEPTH-1:0][PC_WIDTH-1:0] w_pc_vec;
    logic                           w_push;
    logic                           w_pop;
    logic                           w_hit;

    logic [PC_WIDTH-1:0]            r_pc_check;
    logic                           r_is_br_check;
    logic                           r_br_taken_check;
    logic [CNT_WIDTH-1:0]           r_issued_count;

    // Ready comes from registered occupancy only; a pop in the same cycle does not free a slot early.
    assign in_ready = (w_occ != OCC_W'(DEPTH));
    assign w_push   = in_valid && in_ready && in_is_br;
    assign w_pop    = !hold && (w_occ != {OCC_W{1'b0}});

    bp_update_fifo #(
        .PC_WIDTH (PC_WIDTH),
        .DEPTH    (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (reset_n),
        .i_push       (w_push),
        .i_pc         (in_pc),
        .i_taken      (in_taken),
        .i_pop        (w_pop),
        .o_head_pc    (w_head_pc),
        .o_head_taken (w_head_taken),
        .o_occupancy  (w_occ),
        .o_valid      (w_valid),
        .o_pc_vec     (w_pc_vec)
    );

    // Issue register: the strobe lasts one cycle per pop, and the PC and direction hold between pops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc_check       <= {PC_WIDTH{1'b0}};
            r_is_br_check    <= 1'b0;
            r_br_taken_check <= 1'b0;
            r_issued_count   <= {CNT_WIDTH{1'b0}};
        end else if (w_pop) begin
            r_pc_check       <= w_head_pc;
            r_is_br_check    <= 1'b1;
            r_br_taken_check <= w_head_taken;
            r_issued_count   <= r_issued_count + CNT_WIDTH'(1);
        end else begin
            r_pc_check       <= r_pc_check;
            r_is_br_check    <= 1'b0;
            r_br_taken_check <= r_br_taken_check;
            r_issued_count   <= r_issued_count;
        end
    end

    // Stale-guess compare across live FIFO slots and the entry currently on the port.
    always_comb begin
        w_hit = r_is_br_check && (pc_guess == r_pc_check);
        for (int i = 0; i < DEPTH; i++) begin
            if (w_valid[i] && (w_pc_vec[i] == pc_guess)) begin
                w_hit = 1'b1;
            end else begin
                w_hit = w_hit;
            end
        end
    end

    assign pending_hit    = w_hit;
    assign pc_check       = r_pc_check;
    assign is_br_check    = r_is_br_check;
    assign br_taken_check = r_br_taken_check;
    assign occupancy      = w_occ;
    assign issued_count   = r_issued_count;

endmodule

// File: tb/tb_bp_update_scheduler.sv
module tb_bp_update_scheduler;

    localparam int PW = 32;
    localparam int D  = 4;
    localparam int CW = 32;
    localparam int OW = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_pc;
    logic          in_is_br;
    logic          in_taken;
    logic          hold;
    logic [PW-1:0] pc_guess;
    logic          pending_hit;
    logic [PW-1:0] pc_check;
    logic          is_br_check;
    logic          br_taken_check;
    logic [OW-1:0] occupancy;
    logic [CW-1:0] issued_count;

    int total = 0;
    int bad   = 0;

    // Reference model: an ordered queue of {pc,taken} plus the last issued update.
    logic [PW:0]   mq[$];
    logic [PW-1:0] m_pc;
    logic          m_tk;
    logic          m_st;
    logic [CW-1:0] m_cnt;

    always #5 clk = ~clk;

    bp_update_scheduler #(.PC_WIDTH(PW), .DEPTH(D), .CNT_WIDTH(CW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_pc          (in_pc),
        .in_is_br       (in_is_br),
        .in_taken       (in_taken),
        .hold           (hold),
        .pc_guess       (pc_guess),
        .pending_hit    (pending_hit),
        .pc_check       (pc_check),
        .is_br_check    (is_br_check),
        .br_taken_check (br_taken_check),
        .occupancy      (occupancy),
        .issued_count   (issued_count)
    );

    function automatic void model_clear();
        mq.delete();
        m_pc  = '0;
        m_tk  = 1'b0;
        m_st  = 1'b0;
        m_cnt = '0;
    endfunction

    function automatic bit exp_hit(input logic [PW-1:0] g);
        foreach (mq[i]) begin
            if (mq[i][PW:1] == g) return 1'b1;
        end
        return m_st && (m_pc == g);
    endfunction

    // One clock: model applies the rules to the inputs present at the edge; outputs sampled 1ns later.
    task automatic tick();
        int          sz;
        logic [PW:0] e;
        @(posedge clk);
        if (!reset_n) begin
            model_clear();
        end else begin
            sz   = mq.size();
            m_st = 1'b0;
            if (!hold && sz > 0) begin
                e     = mq.pop_front();
                m_pc  = e[PW:1];
                m_tk  = e[0];
                m_st  = 1'b1;
                m_cnt = m_cnt + 1;
            end
            if (in_valid && sz != D && in_is_br) mq.push_back({in_pc, in_taken});
        end
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0; in_pc = '0; in_is_br = 1'b0; in_taken = 1'b0;
        hold = 1'b0; pc_guess = '0;
        reset_n = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (is_br_check !== 1'b0) begin bad++; $display("FAIL reset_strobe: got %b want 0", is_br_check); end
        total++; if (pc_check !== '0) begin bad++; $display("FAIL reset_pc: got %h want 0", pc_check); end
        total++; if (br_taken_check !== 1'b0) begin bad++; $display("FAIL reset_taken: got %b want 0", br_taken_check); end
        total++; if (occupancy !== '0) begin bad++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
        total++; if (issued_count !== '0) begin bad++; $display("FAIL reset_count: got %0d want 0", issued_count); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", in_ready); end
        total++; if (pending_hit !== 1'b0) begin bad++; $display("FAIL reset_hit: got %b want 0", pending_hit); end
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_pc = 32'h10; in_is_br = 1'b1; in_taken = 1'b1;
        tick();
        in_valid = 1'b0;
        total++; if (is_br_check !== 1'b0) begin bad++; $display("FAIL single_early: got %b want 0", is_br_check); end
        total++; if (occupancy !== 3'd1) begin bad++; $display("FAIL single_occ: got %0d want 1", occupancy); end
        tick();
        total++; if (is_br_check !== 1'b1) begin bad++; $display("FAIL single_strobe: got %b want 1", is_br_check); end
        total++; if (pc_check !== 32'h10) begin bad++; $display("FAIL single_pc: got %h want 10", pc_check); end
        total++; if (br_taken_check !== 1'b1) begin bad++; $display("FAIL single_taken: got %b want 1", br_taken_check); end
        total++; if (issued_count !== 32'd1) begin bad++; $display("FAIL single_count: got %0d want 1", issued_count); end
        tick();
        total++; if (is_br_check !== 1'b0) begin bad++; $display("FAIL single_oneshot: got %b want 0", is_br_check); end
        total++; if (pc_check !== 32'h10) begin bad++; $display("FAIL single_pchold: got %h want 10", pc_check); end
        total++; if (issued_count !== 32'd1) begin bad++; $display("FAIL single_count2: got %0d want 1", issued_count); end
    endtask

    task automatic test_full_hold();
        logic [PW-1:0] pcs [4];
        logic          tks [4];
        pcs = '{32'h20, 32'h24, 32'h28, 32'h2C};
        tks = '{1'b1, 1'b0, 1'b1, 1'b0};
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_is_br = 1'b1; in_pc = pcs[i]; in_taken = tks[i];
            tick();
        end
        total++; if (occupancy !== 3'd4) begin bad++; $display("FAIL full_occ: got %0d want 4", occupancy); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_ready: got %b want 0", in_ready); end
        in_pc = 32'h50; in_taken = 1'b1;
        tick();
        in_valid = 1'b0;
        total++; if (occupancy !== 3'd4) begin bad++; $display("FAIL full_fifth: got %0d want 4", occupancy); end
        hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (is_br_check !== 1'b1 || pc_check !== pcs[i] || br_taken_check !== tks[i])
                begin bad++; $display("FAIL full_issue%0d: got %b/%h/%b want 1/%h/%b", i, is_br_check, pc_check, br_taken_check, pcs[i], tks[i]); end
            total++; if (occupancy !== OW'(3 - i)) begin bad++; $display("FAIL full_drain%0d: got %0d want %0d", i, occupancy, 3 - i); end
        end
        tick();
        total++; if (is_br_check !== 1'b0) begin bad++; $display("FAIL full_idle: got %b want 0", is_br_check); end
        total++; if (issued_count !== m_cnt) begin bad++; $display("FAIL full_count: got %0d want %0d", issued_count, m_cnt); end
    endtask

    task automatic test_non_branch();
        in_valid = 1'b1; in_is_br = 1'b0; in_pc = 32'h30; in_taken = 1'b1;
        tick();
        in_valid = 1'b0;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL nonbr_ready: got %b want 1", in_ready); end
        total++; if (occupancy !== '0) begin bad++; $display("FAIL nonbr_occ: got %0d want 0", occupancy); end
        for (int i = 0; i < 3; i++) begin
            total++; if (is_br_check !== 1'b0) begin bad++; $display("FAIL nonbr_strobe%0d: got %b want 0", i, is_br_check); end
            tick();
        end
    endtask

    task automatic test_pending_hit();
        hold = 1'b1;
        in_valid = 1'b1; in_is_br = 1'b1; in_pc = 32'h40; in_taken = 1'b0;
        tick();
        in_valid = 1'b0;
        pc_guess = 32'h40; #1;
        total++; if (pending_hit !== 1'b1) begin bad++; $display("FAIL hit_queued: got %b want 1", pending_hit); end
        pc_guess = 32'h44; #1;
        total++; if (pending_hit !== 1'b0) begin bad++; $display("FAIL hit_miss: got %b want 0", pending_hit); end
        pc_guess = 32'h40; #1;
        hold = 1'b0;
        tick();
        total++; if (is_br_check !== 1'b1 || pending_hit !== 1'b1) begin bad++; $display("FAIL hit_issue: got %b/%b want 1/1", is_br_check, pending_hit); end
        tick();
        total++; if (pending_hit !== 1'b0) begin bad++; $display("FAIL hit_after: got %b want 0", pending_hit); end
    endtask

    task automatic test_back_to_back();
        hold = 1'b1;
        in_valid = 1'b1; in_is_br = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_pc = 32'h100 + 32'(4 * k); in_taken = k[0];
            tick();
        end
        total++; if (occupancy !== 3'd2) begin bad++; $display("FAIL b2b_prefill: got %0d want 2", occupancy); end
        hold = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_pc = 32'h100 + 32'(4 * (i + 2)); in_taken = i[0];
            tick();
            total++; if (occupancy !== 3'd2) begin bad++; $display("FAIL b2b_occ%0d: got %0d want 2", i, occupancy); end
            total++; if (is_br_check !== 1'b1 || pc_check !== 32'h100 + 32'(4 * i) || br_taken_check !== i[0])
                begin bad++; $display("FAIL b2b_issue%0d: got %b/%h/%b want 1/%h/%b", i, is_br_check, pc_check, br_taken_check, 32'h100 + 32'(4 * i), i[0]); end
        end
        in_valid = 1'b0;
        tick(); tick(); tick();
        total++; if (occupancy !== '0) begin bad++; $display("FAIL b2b_drain: got %0d want 0", occupancy); end
        total++; if (issued_count !== m_cnt) begin bad++; $display("FAIL b2b_count: got %0d want %0d", issued_count, m_cnt); end
    endtask

    task automatic test_reset_mid();
        hold = 1'b1;
        in_valid = 1'b1; in_is_br = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_pc = 32'h60 + 32'(4 * k); in_taken = 1'b1;
            tick();
        end
        in_valid = 1'b0; hold = 1'b0;
        tick();
        total++; if (is_br_check !== 1'b1 || pc_check !== 32'h60) begin bad++; $display("FAIL mid_issue: got %b/%h want 1/60", is_br_check, pc_check); end
        #2 reset_n = 1'b0;
        #1;
        model_clear();
        total++; if (is_br_check !== 1'b0 || pc_check !== '0 || br_taken_check !== 1'b0)
            begin bad++; $display("FAIL mid_outputs: got %b/%h/%b want 0/0/0", is_br_check, pc_check, br_taken_check); end
        total++; if (occupancy !== '0 || issued_count !== '0) begin bad++; $display("FAIL mid_state: got %0d/%0d want 0/0", occupancy, issued_count); end
        tick(); tick();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (is_br_check !== 1'b0 || occupancy !== '0) begin bad++; $display("FAIL mid_after%0d: got %b/%0d want 0/0", i, is_br_check, occupancy); end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_is_br = ($urandom_range(0, 3) != 0);
            in_taken = 1'($urandom_range(0, 1));
            in_pc    = 32'h1000 + 32'(4 * $urandom_range(0, 7));
            hold     = ($urandom_range(0, 2) == 0);
            pc_guess = 32'h1000 + 32'(4 * $urandom_range(0, 7));
            #1;
            total++; if (pending_hit !== exp_hit(pc_guess)) begin bad++; $display("FAIL rnd_hit%0d: got %b want %b", c, pending_hit, exp_hit(pc_guess)); end
            total++; if (in_ready !== (mq.size() != D)) begin bad++; $display("FAIL rnd_ready%0d: got %b want %b", c, in_ready, mq.size() != D); end
            tick();
            total++; if (is_br_check !== m_st || pc_check !== m_pc || br_taken_check !== m_tk)
                begin bad++; $display("FAIL rnd_port%0d: got %b/%h/%b want %b/%h/%b", c, is_br_check, pc_check, br_taken_check, m_st, m_pc, m_tk); end
            total++; if (occupancy !== OW'(mq.size()) || issued_count !== m_cnt)
                begin bad++; $display("FAIL rnd_state%0d: got %0d/%0d want %0d/%0d", c, occupancy, issued_count, mq.size(), m_cnt); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full_hold();
        test_non_branch();
        test_pending_hit();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
